// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 constants and byte-lane helpers for the
// MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unused funct3 encodings are reported as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a returned load word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {offset, 3'b000});
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data = {24'b0, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data = {16'b0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data bus and stalls the
// pipeline until each access completes. Bus watchdog enabled by MEM_STAGE_TIMEOUT_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_mem_out,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic        out_misaligned,
  output logic        out_bus_error
);

  lsu_state_e  state_q, state_d;
  logic [31:0] load_q, load_aligned;
  logic        is_mem, is_load, misaligned;
  logic        capture, req, stall_c, valid_c, misal_c, done_c;
  logic        timeout, bus_err;

  assign is_mem     = in_valid & (in_mem_read | in_mem_write);
  assign is_load    = in_mem_read;
  assign misaligned = is_misaligned(in_funct3, in_alu_out[1:0]);

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (in_alu_out[1:0]),
    .funct3 (in_funct3),
    .data   (load_aligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      load_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      if (capture) load_q <= load_aligned;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no branch leaves a latch behind.
    state_d = state_q;
    capture = 1'b0;
    req     = 1'b0;
    stall_c = 1'b0;
    valid_c = 1'b0;
    misal_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          valid_c = in_valid;
        end else if (misaligned) begin
          valid_c = 1'b1;
          misal_c = 1'b1;
        end else begin
          req     = 1'b1;
          stall_c = 1'b1;
          if (dmem_gnt) state_d = is_load ? S_RSP : S_DONE;
          else          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req     = 1'b1;
        stall_c = 1'b1;
        if (dmem_gnt) begin
          if (!is_load) begin
            state_d = S_DONE;
          end else if (dmem_rvalid) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RSP;
          end
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_RSP: begin
        stall_c = 1'b1;
        if (dmem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_c = 1'b1;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign timeout = (cnt_q == 8'(TIMEOUT_CYC - 1));
  assign bus_err = err_q;

  // Counter restarts on every IDLE exit; the error flag is frozen through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE)      cnt_q <= '0;
      else if (state_q != S_DONE) cnt_q <= cnt_q + 8'd1;
      if (state_q != S_DONE)
        err_q <= timeout & (((state_q == S_REQ) & ~dmem_gnt) |
                            ((state_q == S_RSP) & ~dmem_rvalid));
    end
  end
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Everything is forced low while reset is held, including the passthroughs.
  assign dmem_req         = reset & req;
  assign dmem_we          = dmem_req & ~is_load;
  assign dmem_addr        = dmem_req ? {in_alu_out[31:2], 2'b00} : '0;
  assign dmem_be          = dmem_req ? byte_enable(in_funct3, in_alu_out[1:0]) : '0;
  assign dmem_wdata       = dmem_we ? store_lanes(in_funct3, in_store_data) : '0;
  assign stall            = reset & stall_c;
  assign out_valid        = reset & valid_c;
  assign out_alu_out      = reset ? in_alu_out : '0;
  assign out_rd           = reset ? in_rd : '0;
  assign out_mem_to_reg   = reset & in_mem_to_reg;
  assign out_mem_out      = (out_valid & done_c & is_load & ~bus_err) ? load_q : '0;
  assign out_write_enable = out_valid & in_write_enable & ~misal_c & ~(done_c & bus_err);
  assign out_misaligned   = reset & misal_c;
  assign out_bus_error    = out_valid & done_c & bus_err;

endmodule
